mesh_store_initiator: RTL and testbench
=======================================

Name: mesh_store_initiator

Overview:
- Mesh endpoint that sends a block of words from a local read-only buffer to a remote tile, such as the mesh_nn accelerator.
- Emits one remote-store packet per word to (dest_x_i, dest_y_i), with the source set to (my_x_i, my_y_i).
- Out-of-order store acknowledgements are throttled by a credit counter.
- Serves as the host/loader-side counterpart of the accelerator's mesh receive port: used to load weights and inputs before compute.

Parameters:
- x_cord_width_p, 2, X coordinate width
- y_cord_width_p, 2, Y coordinate width
- data_width_p, 32, payload word width
- addr_width_p, 10, remote/local word address width
- max_out_credits_p, 8, maximum unacknowledged stores in flight (>=1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- my_x_i  in  x_cord_width_p  own X coordinate
- my_y_i  in  y_cord_width_p  own Y coordinate
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  addr_width_p  first local and remote word address; latched on start
- len_i  in  addr_width_p+1  word count, 0..2^addr_width_p; latched on start
- dest_x_i  in  x_cord_width_p  target X; latched on start
- dest_y_i  in  y_cord_width_p  target Y; latched on start
- mem_v_o  out  1  local buffer read strobe
- mem_addr_o  out  addr_width_p  local read address
- mem_data_i  in  data_width_p  read data, valid exactly 1 cycle after mem_v_o
- pkt_v_o  out  1  outgoing store packet valid
- pkt_ready_i  in  1  network accepts packet when pkt_v_o & pkt_ready_i
- pkt_data_o  out  data_width_p  store payload
- pkt_addr_o  out  addr_width_p  remote word address
- pkt_x_o  out  x_cord_width_p  destination X
- pkt_y_o  out  y_cord_width_p  destination Y
- pkt_src_x_o  out  x_cord_width_p  source X (= my_x_i)
- pkt_src_y_o  out  y_cord_width_p  source Y (= my_y_i)
- resp_v_i  in  1  one store acknowledgement (credit return) per cycle
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse when transfer fully acknowledged
- err_o  out  1  sticky: credit return received with counter already at max

Behaviour:
- Reset values:
  - FSM=IDLE, credits=max_out_credits_p, word index=0.
  - All outputs 0, including mem_v_o, pkt_v_o, busy_o, done_o, err_o.
  - Reset mid-transfer aborts immediately. In-flight acks arriving after reset are counted as err if credits are full.
- IDLE:
  - start_i & len_i!=0: latch base/len/dest, go to READ.
  - start_i & len_i==0: done_o=1 the next cycle, stay IDLE, busy_o stays 0.
- READ (1 cycle):
  - mem_v_o=1, mem_addr_o=base+idx, modulo 2^addr_width_p (wraps).
  - Go to SEND.
- SEND:
  - Register mem_data_i on the first SEND cycle; the payload holds stable until accepted.
  - pkt_v_o=1 only when credits>0.
  - pkt_addr_o=base+idx (wraps); pkt_x/y from latched dest.
  - While pkt_v_o is high, pkt_* must not change.
  - On accept: idx++. If idx+1==len go to DRAIN, else go to READ.
  - Throughput: 1 word per 2 cycles when never stalled.
- DRAIN:
  - Wait until credits==max_out_credits_p.
  - Then done_o=1 for one cycle, go to IDLE.
- Credit counter, width clog2(max+1):
  - Decrements on accept; increments on resp_v_i.
  - Accept and resp_v_i in the same cycle: net unchanged.
  - resp_v_i at max with no simultaneous accept: counter holds, err_o set (cleared only by reset).
- start_i while busy: ignored.
- resp_v_i is accepted in every state, including IDLE.
- Latency: first packet valid 2 cycles after start with credits available.
- Transfer lengths:
  - len=2^addr_width_p sends every address exactly once.
  - Address wraps from 2^addr_width_p-1 to 0.

Test Plan:
1. Basic transfer:
   - Stimulus: base=0x010, len=4, dest=(1,1), my=(0,0), pkt_ready=1, acks 3 cycles after each send.
   - Required: 4 packets with addr 0x010..0x013 and data equal to the buffer contents; pkt_v first seen 2 cycles after start; done_o pulses once after the 4th ack; busy_o drops with done.
2. Credit stall:
   - Stimulus: max=8, len=12, no acks until 8 sent.
   - Required: exactly 8 packets, then pkt_v_o=0. Each later ack releases exactly one packet. done_o only after 12 acks.
3. Backpressure:
   - Stimulus: pkt_ready_i low for 5 cycles mid-packet.
   - Required: pkt_data_o/pkt_addr_o stable throughout; no duplicate or dropped words.
4. Wrap and simultaneous events:
   - Stimulus: base=0x3FE, len=4, with ack arriving on the same cycles as accepts.
   - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001; credit count unchanged on coincident cycles.
5. Zero length and ignored start:
   - Stimulus: start with len=0; then start during an active transfer.
   - Required: zero length gives done_o after 1 cycle with no packets. The second start is ignored and the original transfer completes unchanged.
6. Reset and error:
   - Stimulus: reset asserted mid-SEND; then an extra resp_v_i with credits full.
   - Required: all outputs 0 the cycle after reset; err_o=1 and stays 1 until the next reset.

Source files
------------

// File: rtl/mesh_store_initiator.sv
// Mesh store initiator: streams a block of local buffer words to a remote tile as
// one remote-store packet per word, throttled by a credit counter fed by store acks.
module mesh_store_initiator #(
  parameter int x_cord_width_p    = 2,
  parameter int y_cord_width_p    = 2,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 10,
  parameter int max_out_credits_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      start_i,
  input  logic [addr_width_p-1:0]   base_addr_i,
  input  logic [addr_width_p:0]     len_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  output logic                      mem_v_o,
  output logic [addr_width_p-1:0]   mem_addr_o,
  input  logic [data_width_p-1:0]   mem_data_i,
  output logic                      pkt_v_o,
  input  logic                      pkt_ready_i,
  output logic [data_width_p-1:0]   pkt_data_o,
  output logic [addr_width_p-1:0]   pkt_addr_o,
  output logic [x_cord_width_p-1:0] pkt_x_o,
  output logic [y_cord_width_p-1:0] pkt_y_o,
  output logic [x_cord_width_p-1:0] pkt_src_x_o,
  output logic [y_cord_width_p-1:0] pkt_src_y_o,
  input  logic                      resp_v_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int credit_w_lp = $clog2(max_out_credits_p + 1);
  localparam int len_w_lp    = addr_width_p + 1;
  localparam logic [credit_w_lp-1:0] credit_max_lp = credit_w_lp'(max_out_credits_p);

  typedef enum logic [1:0] {IDLE, READ, SEND, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [addr_width_p-1:0]   base_q;
  logic [len_w_lp-1:0]       len_q;
  logic [len_w_lp-1:0]       idx_q;
  logic [x_cord_width_p-1:0] dest_x_q;
  logic [y_cord_width_p-1:0] dest_y_q;
  logic [credit_w_lp-1:0]    credits_q;
  logic [credit_w_lp:0]      credit_upd;
  logic                      err_q;
  logic                      done_q, done_d;
  logic                      vld_p1;
  logic [data_width_p-1:0]   data_p1;
  logic [data_width_p-1:0]   payload;
  logic [addr_width_p-1:0]   word_addr;
  logic                      start_go, start_empty, accept, last_word, in_send;

  // Saturating credit update; the extra top bit flags a return that found the counter full.
  function automatic logic [credit_w_lp:0] credit_step(
    input logic [credit_w_lp-1:0] cur,
    input logic                   take,
    input logic                   give
  );
    logic [credit_w_lp:0] r;
    r = {1'b0, cur};
    if (take && !give) begin
      r = {1'b0, cur - credit_w_lp'(1)};
    end else if (give && !take) begin
      if (cur == credit_max_lp) r = {1'b1, cur};
      else                      r = {1'b0, cur + credit_w_lp'(1)};
    end
    return r;
  endfunction

  assign in_send     = (state_q == SEND);
  assign start_go    = (state_q == IDLE) && start_i && (len_i != '0);
  assign start_empty = (state_q == IDLE) && start_i && (len_i == '0);
  assign word_addr   = base_q + idx_q[addr_width_p-1:0];
  assign last_word   = ((idx_q + len_w_lp'(1)) == len_q);
  assign pkt_v_o     = in_send && (credits_q != '0);
  assign accept      = pkt_v_o && pkt_ready_i;
  assign credit_upd  = credit_step(credits_q, accept, resp_v_i);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_go) state_d = READ;
        done_d = start_empty;
      end
      READ: state_d = SEND;
      SEND: begin
        if (accept) state_d = last_word ? DRAIN : READ;
      end
      DRAIN: begin
        if (credits_q == credit_max_lp) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      credits_q <= credit_max_lp;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      vld_p1    <= (state_q == READ);
      credits_q <= credit_upd[credit_w_lp-1:0];
      if (credit_upd[credit_w_lp]) err_q <= 1'b1;
      if (start_go)    idx_q <= '0;
      else if (accept) idx_q <= idx_q + len_w_lp'(1);
    end
  end

  // Stage p1: read data arrives one cycle after the strobe and is held until accepted.
  always_ff @(posedge clk_i) begin
    if (start_go) begin
      base_q   <= base_addr_i;
      len_q    <= len_i;
      dest_x_q <= dest_x_i;
      dest_y_q <= dest_y_i;
    end
    if (vld_p1) data_p1 <= mem_data_i;
  end

  // First SEND cycle forwards the live read data so the packet can go out immediately.
  assign payload = vld_p1 ? mem_data_i : data_p1;

  assign mem_v_o     = (state_q == READ);
  assign mem_addr_o  = mem_v_o ? word_addr : '0;
  assign pkt_data_o  = in_send ? payload   : '0;
  assign pkt_addr_o  = in_send ? word_addr : '0;
  assign pkt_x_o     = in_send ? dest_x_q  : '0;
  assign pkt_y_o     = in_send ? dest_y_q  : '0;
  assign pkt_src_x_o = in_send ? my_x_i    : '0;
  assign pkt_src_y_o = in_send ? my_y_i    : '0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mesh_store_initiator.sv
// Self-checking bench for mesh_store_initiator: a transaction-level model of the
// transfer rules checked every cycle, plus directed scenarios with literal expectations.
module tb_mesh_store_initiator;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MAXC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] my_x = 2'd0, my_y = 2'd0;
  logic start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0] len_i = '0;
  logic [1:0] dest_x_i = '0, dest_y_i = '0;
  logic mem_v_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i = '0;
  logic pkt_v_o;
  logic pkt_ready_i = 1'b1;
  logic [DW-1:0] pkt_data_o;
  logic [AW-1:0] pkt_addr_o;
  logic [1:0] pkt_x_o, pkt_y_o, pkt_src_x_o, pkt_src_y_o;
  logic resp_v_i = 1'b0;
  logic busy_o, done_o, err_o;

  always #5 clk = ~clk;

  mesh_store_initiator #(
    .x_cord_width_p(2), .y_cord_width_p(2), .data_width_p(DW),
    .addr_width_p(AW), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk), .reset_i(rst), .my_x_i(my_x), .my_y_i(my_y),
    .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .dest_x_i(dest_x_i), .dest_y_i(dest_y_i),
    .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .pkt_v_o(pkt_v_o), .pkt_ready_i(pkt_ready_i), .pkt_data_o(pkt_data_o),
    .pkt_addr_o(pkt_addr_o), .pkt_x_o(pkt_x_o), .pkt_y_o(pkt_y_o),
    .pkt_src_x_o(pkt_src_x_o), .pkt_src_y_o(pkt_src_y_o),
    .resp_v_i(resp_v_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int cyc = 0, n_checks = 0, n_err = 0;
  bit check_en = 1'b0, auto_ack = 1'b0;
  int ack_delay = 3;
  int ack_due[$];
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] acc_data[$];
  logic [1:0] acc_x[$];
  int pkt_cnt = 0, done_cnt = 0, first_pv = -1, start_cyc = 0;

  // Reference model state: what the transfer must look like from the outside.
  bit m_active = 0, m_fetch = 0, m_offer = 0, m_drain = 0, m_done = 0, m_err = 0;
  int m_credits = MAXC, m_idx = 0, m_len = 0, m_base = 0;
  logic [1:0] m_dx = '0, m_dy = '0;
  bit hold_prev = 0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;

  function automatic logic [DW-1:0] mem_word(input int a);
    return 32'h5A00_0000 + 32'(a * 17);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Local buffer: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk)
    mem_data_i <= mem_v_o ? mem_word(int'(mem_addr_o)) : $urandom();

  always @(negedge clk) begin
    bit exp_pv, acc, nxt_done;
    int exp_addr;
    exp_pv = m_offer && (m_credits > 0);
    exp_addr = (m_base + m_idx) % (1 << AW);
    if (check_en) begin
      chk("busy", busy_o, m_active);
      chk("done", done_o, m_done);
      chk("err", err_o, m_err);
      chk("mem_v", mem_v_o, m_fetch);
      if (m_fetch) chk("mem_addr", mem_addr_o, exp_addr);
      chk("pkt_v", pkt_v_o, exp_pv);
      if (exp_pv) begin
        chk("pkt_addr", pkt_addr_o, exp_addr);
        chk("pkt_data", pkt_data_o, mem_word(exp_addr));
        chk("pkt_x", pkt_x_o, m_dx);
        chk("pkt_y", pkt_y_o, m_dy);
        chk("pkt_src_x", pkt_src_x_o, my_x);
        chk("pkt_src_y", pkt_src_y_o, my_y);
      end
      if (hold_prev) begin
        chk("hold_v", pkt_v_o, 1);
        chk("hold_data", pkt_data_o, prev_data);
        chk("hold_addr", pkt_addr_o, prev_addr);
      end
      hold_prev = pkt_v_o && !pkt_ready_i;
      prev_data = pkt_data_o;
      prev_addr = pkt_addr_o;
      if (pkt_v_o && first_pv < 0) first_pv = cyc;
      if (pkt_v_o && pkt_ready_i) begin
        acc_addr.push_back(pkt_addr_o);
        acc_data.push_back(pkt_data_o);
        acc_x.push_back(pkt_x_o);
        pkt_cnt++;
        if (auto_ack) ack_due.push_back(cyc + ack_delay);
      end
      if (done_o) done_cnt++;
    end
    // Advance the model across the coming clock edge.
    if (rst) begin
      m_active = 0; m_fetch = 0; m_offer = 0; m_drain = 0;
      m_done = 0; m_err = 0; m_credits = MAXC; m_idx = 0; hold_prev = 0;
    end else begin
      acc = exp_pv && pkt_ready_i;
      nxt_done = 0;
      if (!m_active) begin
        if (start_i) begin
          if (len_i == 0) nxt_done = 1;
          else begin
            m_active = 1; m_fetch = 1; m_idx = 0;
            m_base = int'(base_addr_i); m_len = int'(len_i);
            m_dx = dest_x_i; m_dy = dest_y_i;
          end
        end
      end else if (m_fetch) begin
        m_fetch = 0; m_offer = 1;
      end else if (m_offer) begin
        if (acc) begin
          m_idx++; m_offer = 0;
          if (m_idx == m_len) m_drain = 1;
          else m_fetch = 1;
        end
      end else if (m_drain && m_credits == MAXC) begin
        m_drain = 0; m_active = 0; nxt_done = 1;
      end
      if (acc && !resp_v_i) m_credits--;
      else if (resp_v_i && !acc) begin
        if (m_credits == MAXC) m_err = 1;
        else m_credits++;
      end
      m_done = nxt_done;
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    start_i = 1'b0;
    resp_v_i = 1'b0;
    if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
      void'(ack_due.pop_front());
      resp_v_i = 1'b1;
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l,
                            input logic [1:0] dx, input logic [1:0] dy);
    base_addr_i = b; len_i = l; dest_x_i = dx; dest_y_i = dy;
    start_i = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic clear_log();
    acc_addr.delete(); acc_data.delete(); acc_x.delete();
    pkt_cnt = 0; done_cnt = 0; first_pv = -1;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done_o === 1'b1) begin found = 1; break; end
    end
    chk(name, found, 1);
  endtask

  task automatic wait_pkt(input int n, input int limit, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (pkt_cnt >= n && pkt_v_o === 1'b1) begin found = 1; break; end
    end
    chk(name, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dups, distinct;
    bit seen [1024];
    rst = 1'b1;
    step();
    check_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_pkt_v", pkt_v_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_err", err_o, 0);

    // Basic transfer
    clear_log(); auto_ack = 1; ack_delay = 3;
    start_xfer(10'h010, 11'd4, 2'd1, 2'd1);
    wait_done(80, "t1_done_seen");
    chk("t1_busy_with_done", busy_o, 0);
    step();
    chk("t1_latency", first_pv - start_cyc, 2);
    chk("t1_pkts", pkt_cnt, 4);
    chk("t1_done_cnt", done_cnt, 1);
    for (int i = 0; i < 4; i++) chk("t1_addr", acc_addr[i], 10'h010 + 10'(i));
    chk("t1_data0", acc_data[0], 32'h5A00_0110);
    chk("t1_data3", acc_data[3], 32'h5A00_0143);

    // Credit stall
    clear_log(); auto_ack = 0;
    start_xfer(10'h100, 11'd12, 2'd2, 2'd1);
    repeat (40) step();
    chk("t2_stall_pkts", pkt_cnt, 8);
    chk("t2_stall_v", pkt_v_o, 0);
    for (int k = 0; k < 4; k++) begin
      resp_v_i = 1'b1;
      step();
      repeat (5) step();
      chk("t2_release", pkt_cnt, 9 + k);
    end
    for (int k = 0; k < 7; k++) begin
      resp_v_i = 1'b1;
      step();
    end
    repeat (3) step();
    chk("t2_no_early_done", done_cnt, 0);
    chk("t2_still_busy", busy_o, 1);
    resp_v_i = 1'b1;
    wait_done(10, "t2_done_seen");
    step();
    chk("t2_done_cnt", done_cnt, 1);

    // Backpressure
    clear_log(); auto_ack = 1; ack_delay = 2;
    start_xfer(10'h020, 11'd3, 2'd1, 2'd2);
    wait_pkt(1, 20, "t3_second_offer");
    pkt_ready_i = 1'b0;
    repeat (5) step();
    chk("t3_bp_v", pkt_v_o, 1);
    chk("t3_bp_addr", pkt_addr_o, 10'h021);
    chk("t3_bp_data", pkt_data_o, 32'h5A00_0231);
    pkt_ready_i = 1'b1;
    wait_done(40, "t3_done_seen");
    step();
    chk("t3_pkts", pkt_cnt, 3);
    for (int i = 0; i < 3; i++) chk("t3_addr", acc_addr[i], 10'h020 + 10'(i));

    // Wrap with acks coinciding with accepts
    clear_log(); ack_delay = 2;
    start_xfer(10'h3FE, 11'd4, 2'd3, 2'd3);
    wait_done(60, "t4_done_seen");
    step();
    chk("t4_pkts", pkt_cnt, 4);
    chk("t4_addr0", acc_addr[0], 10'h3FE);
    chk("t4_addr1", acc_addr[1], 10'h3FF);
    chk("t4_addr2", acc_addr[2], 10'h000);
    chk("t4_addr3", acc_addr[3], 10'h001);

    // Zero length, then a start while busy
    clear_log(); ack_delay = 3;
    start_xfer(10'h055, 11'd0, 2'd1, 2'd1);
    step();
    chk("t5_zero_done", done_o, 1);
    chk("t5_zero_busy", busy_o, 0);
    step();
    chk("t5_zero_done_pulse", done_o, 0);
    chk("t5_zero_pkts", pkt_cnt, 0);
    clear_log();
    start_xfer(10'h040, 11'd3, 2'd2, 2'd3);
    repeat (3) step();
    start_xfer(10'h200, 11'd5, 2'd3, 2'd2);
    wait_done(60, "t5_done_seen");
    step();
    chk("t5_pkts", pkt_cnt, 3);
    chk("t5_done_cnt", done_cnt, 1);
    for (int i = 0; i < 3; i++) chk("t5_addr", acc_addr[i], 10'h040 + 10'(i));
    chk("t5_dest_x", acc_x[2], 2'd2);

    // Full address space
    clear_log(); ack_delay = 1;
    start_xfer(10'h2A0, 11'd1024, 2'd1, 2'd0);
    wait_done(2300, "full_done_seen");
    step();
    dups = 0; distinct = 0;
    foreach (acc_addr[i]) begin
      if (seen[acc_addr[i]]) dups++;
      else begin seen[acc_addr[i]] = 1; distinct++; end
    end
    chk("full_pkts", pkt_cnt, 1024);
    chk("full_dups", dups, 0);
    chk("full_distinct", distinct, 1024);

    // Reset mid-SEND, then credit return with counter full
    clear_log(); ack_delay = 4;
    start_xfer(10'h080, 11'd6, 2'd3, 2'd1);
    wait_pkt(2, 30, "t6_third_offer");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_mem_v", mem_v_o, 0);
    chk("t6_mem_addr", mem_addr_o, 0);
    chk("t6_pkt_v", pkt_v_o, 0);
    chk("t6_pkt_data", pkt_data_o, 0);
    chk("t6_pkt_addr", pkt_addr_o, 0);
    chk("t6_pkt_xy", {pkt_x_o, pkt_y_o, pkt_src_x_o, pkt_src_y_o}, 0);
    repeat (10) step();
    resp_v_i = 1'b1;
    step();
    repeat (3) step();
    chk("t6_err_set", err_o, 1);
    repeat (20) step();
    chk("t6_err_sticky", err_o, 1);
    ack_due.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_cleared", err_o, 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
